// File: rtl/cpu_io_pkg.sv
// Shared register map, STATUS bit positions and transmitter state encoding
// for the memory-mapped serial transmit peripheral.
package cpu_io_pkg;
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV_LO = 2'd2;
  localparam logic [1:0] REG_DIV_HI = 2'd3;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_PAR   = 3;
  localparam int ST_BUSY  = 7;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push while full is taken only when a pop frees a slot
// in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     n_reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == DEPTH[AW:0]);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/uart_tx_io.sv
// Bus-mapped 8N1 transmitter: DATA/STATUS/DIV_LO/DIV_HI window, TX FIFO, serialiser.
// Optional even-parity bit and STATUS bit3 enable when UART_TX_PARITY_EN is defined.
module uart_tx_io
  import cpu_io_pkg::*;
#(
  parameter logic [15:0] BASE_ADR    = 16'hD000,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic                          clk,
  input  logic                          n_reset,
  input  logic [15:0]                   adr_bus,
  input  logic [7:0]                    data_bus_in,
  input  logic                          RW,
  output logic [7:0]                    data_bus_out,
  output logic                          sel,
  output logic                          tx,
  output logic [$clog2(FIFO_DEPTH):0]   dbg_fifo_count
);
  tx_state_t   state, nstate;
  logic [1:0]  off;
  logic        wr_en, rd_en, push, pop, full, empty, ovf, bit_end;
  logic [7:0]  fifo_dout, shift, status;
  logic [15:0] div, cnt, per_m1;
  logic [2:0]  bit_idx;
  logic        par_en, par_bit;

  assign off    = adr_bus[1:0];
  assign sel    = (adr_bus[15:2] == BASE_ADR[15:2]);
  assign wr_en  = sel & ~RW;
  assign rd_en  = sel & RW;
  assign push   = wr_en & (off == REG_DATA);
  assign per_m1 = (div == 16'd0) ? 16'd0 : div - 16'd1;
  assign bit_end = (cnt == 16'd0);

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .n_reset(n_reset), .push(push), .pop(pop), .din(data_bus_in),
    .dout(fifo_dout), .full(full), .empty(empty), .count(dbg_fifo_count)
  );

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)                           par_en <= 1'b0;
    else if (wr_en && off == REG_STATUS)    par_en <= data_bus_in[ST_PAR];
  end
`else
  assign par_en = 1'b0;
`endif

  // Register writes and the sticky overflow flag (cleared by any STATUS read)
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      div <= DEFAULT_DIV;
      ovf <= 1'b0;
    end else begin
      if (wr_en && off == REG_DIV_LO) div[7:0]  <= data_bus_in;
      if (wr_en && off == REG_DIV_HI) div[15:8] <= data_bus_in;
      if (push && full && !pop)                ovf <= 1'b1;
      else if (rd_en && off == REG_STATUS)     ovf <= 1'b0;
    end
  end

  always_comb begin
    status          = 8'h00;
    status[ST_FULL]  = full;
    status[ST_EMPTY] = empty;
    status[ST_OVF]   = ovf;
    status[ST_PAR]   = par_en;
    status[ST_BUSY]  = (state != IDLE) | ~empty;
  end

  always_comb begin
    data_bus_out = 8'h00;
    if (sel) begin
      case (off)
        REG_STATUS: data_bus_out = status;
        REG_DIV_LO: data_bus_out = div[7:0];
        REG_DIV_HI: data_bus_out = div[15:8];
        default:    data_bus_out = 8'h00;
      endcase
    end
  end

  always_comb begin
    nstate = state;
    pop    = 1'b0;
    tx     = 1'b1;
    case (state)
      IDLE: if (!empty) begin
        pop    = 1'b1;
        nstate = START;
      end
      START: begin
        tx = 1'b0;
        if (bit_end) nstate = DATA;
      end
      DATA: begin
        tx = shift[0];
        if (bit_end && bit_idx == 3'd7) nstate = par_en ? PARITY : STOP;
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx = par_bit;
        if (bit_end) nstate = STOP;
      end
`endif
      STOP: if (bit_end) begin
        // back-to-back frames: pop straight into the next start bit
        if (!empty) begin
          pop    = 1'b1;
          nstate = START;
        end else begin
          nstate = IDLE;
        end
      end
      default: nstate = IDLE;
    endcase
  end

  // Counter reloads on every bit boundary, so a DIV change takes effect on the next bit
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state   <= IDLE;
      cnt     <= 16'd0;
      shift   <= 8'h00;
      bit_idx <= 3'd0;
      par_bit <= 1'b0;
    end else begin
      state <= nstate;
      if (nstate == IDLE)                            cnt <= 16'd0;
      else if (nstate != state || (state == DATA && bit_end)) cnt <= per_m1;
      else                                           cnt <= cnt - 16'd1;
      if (pop) begin
        shift   <= fifo_dout;
        bit_idx <= 3'd0;
        par_bit <= ^fifo_dout;
      end else if (state == DATA && bit_end) begin
        shift   <= shift >> 1;
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_io.sv
// Directed/randomised bench for uart_tx_io: register reads, framing, FIFO
// overflow, back-to-back frames, async reset and (if enabled) parity.
module tb_uart_tx_io;
  localparam int          DEPTH = 4;
  localparam logic [15:0] BASE  = 16'hD000;
  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0, n_reset = 1'b0, RW = 1'b1;
  logic [15:0] adr_bus = 16'h0000;
  logic [7:0]  data_bus_in = 8'h00;
  logic [7:0]  data_bus_out;
  logic        sel, tx;
  logic [$clog2(DEPTH):0] dbg_fifo_count;

  int total = 0, bad = 0, cyc = 0;
  logic txlog [0:16383];

  uart_tx_io #(.BASE_ADR(BASE), .FIFO_DEPTH(DEPTH), .DEFAULT_DIV(16'd434)) dut (
    .clk(clk), .n_reset(n_reset), .adr_bus(adr_bus), .data_bus_in(data_bus_in),
    .RW(RW), .data_bus_out(data_bus_out), .sel(sel), .tx(tx),
    .dbg_fifo_count(dbg_fifo_count)
  );

  always #5 clk = ~clk;

  // line sampled on every falling edge; index k+1 holds tx after the posedge that left cyc==k
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (cyc < 16384) txlog[cyc] = tx;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [1:0] off, input logic [7:0] d, output int c);
    @(negedge clk);
    adr_bus = BASE | {14'd0, off}; data_bus_in = d; RW = 1'b0;
    @(posedge clk);
    c = cyc;
    #1 adr_bus = 16'h0000; RW = 1'b1;
  endtask

  task automatic bus_rd(input logic [1:0] off, output logic [7:0] d);
    @(negedge clk);
    adr_bus = BASE | {14'd0, off}; RW = 1'b1;
    #1 d = data_bus_out;
    @(posedge clk);
    #1 adr_bus = 16'h0000;
  endtask

  // Expected line: for each byte a start bit, 8 data bits LSB first, optional
  // even parity, stop bit, each max(div,1) clocks; then three idle clocks.
  task automatic check_line(input string tag, input int start, input bq_t q,
                            input int div, input bit par);
    logic exp_bits[$];
    int per, ok, guard, last;
    per = (div < 1) ? 1 : div;
    foreach (q[b]) begin
      logic [7:0] v;
      v = q[b];
      repeat (per) exp_bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) repeat (per) exp_bits.push_back(v[i]);
      if (par) repeat (per) exp_bits.push_back(^v);
      repeat (per) exp_bits.push_back(1'b1);
    end
    repeat (3) exp_bits.push_back(1'b1);
    last = start + exp_bits.size() - 1;
    guard = 0;
    while (cyc < last && guard < 5000) begin
      @(negedge clk); #1; guard++;
    end
    if (cyc < last) begin
      chk({tag, "_timeout"}, cyc, last);
    end else begin
      ok = 0;
      foreach (exp_bits[i]) if (txlog[start + i] === exp_bits[i]) ok++;
      chk(tag, ok, exp_bits.size());
    end
  endtask

  initial begin
    logic [7:0] d, b0, b1, b2;
    int c, c0, dv;
    bq_t q;

    // reset state
    repeat (3) @(posedge clk);
    #1 chk("rst_tx", tx, 1'b1);
    chk("rst_count", dbg_fifo_count, 0);
    @(negedge clk) n_reset = 1'b1;
    bus_rd(2'd1, d); chk("rst_status", d, 8'h02);
    bus_rd(2'd2, d); chk("rst_div_lo", d, 8'hB2);
    bus_rd(2'd3, d); chk("rst_div_hi", d, 8'h01);
    bus_rd(2'd0, d); chk("rd_data", d, 8'h00);
    chk("idle_tx", tx, 1'b1);

    // DIV=4, single 0x55 frame
    bus_wr(2'd2, 8'd4, c); bus_wr(2'd3, 8'd0, c);
    bus_rd(2'd2, d); chk("div_lo_rb", d, 8'h04);
    bus_wr(2'd0, 8'h55, c0);
    q = {}; q.push_back(8'h55);
    check_line("frame_55", c0 + 2, q, 4, 1'b0);
    bus_rd(2'd1, d); chk("busy_clear", d, 8'h02);

    // random divisor, two queued random bytes
    dv = $urandom_range(1, 5);
    b0 = 8'($urandom); b1 = 8'($urandom);
    bus_wr(2'd2, 8'(dv), c);
    bus_wr(2'd0, b0, c0); bus_wr(2'd0, b1, c);
    q = {}; q.push_back(b0); q.push_back(b1);
    check_line("frame_rand", c0 + 2, q, dv, 1'b0);

    // DIV=2: five bytes fill the FIFO behind the first frame, sixth overflows
    bus_wr(2'd2, 8'd2, c);
    q = {};
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom);
      q.push_back(d);
      bus_wr(2'd0, d, c);
      if (i == 0) c0 = c;
    end
    bus_wr(2'd0, 8'($urandom), c);
    chk("ovf_count", dbg_fifo_count, DEPTH);
    bus_rd(2'd1, d); chk("ovf_status", d, 8'h85);
    bus_rd(2'd1, d); chk("ovf_cleared", d, 8'h81);
    check_line("frame_burst", c0 + 2, q, 2, 1'b0);

    // DIV=0 acts as 1: three contiguous frames
    bus_wr(2'd2, 8'd0, c);
    b1 = 8'($urandom); b2 = 8'($urandom);
    bus_wr(2'd0, 8'hFF, c0); bus_wr(2'd0, b1, c); bus_wr(2'd0, b2, c);
    q = {}; q.push_back(8'hFF); q.push_back(b1); q.push_back(b2);
    check_line("frame_div0", c0 + 2, q, 0, 1'b0);

    // async reset in the middle of the data bits
    bus_wr(2'd2, 8'd4, c);
    bus_wr(2'd0, 8'hA5, c); bus_wr(2'd0, 8'h3C, c);
    repeat (20) @(posedge clk);
    #2 n_reset = 1'b0;
    #1 chk("midrst_tx", tx, 1'b1);
    chk("midrst_count", dbg_fifo_count, 0);
    @(negedge clk) n_reset = 1'b1;
    bus_rd(2'd1, d); chk("midrst_status", d, 8'h02);
    bus_rd(2'd2, d); chk("midrst_div_lo", d, 8'hB2);
    bus_rd(2'd3, d); chk("midrst_div_hi", d, 8'h01);

`ifdef UART_TX_PARITY_EN
    bus_wr(2'd1, 8'hFF, c);
    bus_rd(2'd1, d); chk("par_en_rb", d, 8'h0A);
    bus_wr(2'd2, 8'd3, c); bus_wr(2'd3, 8'd0, c);
    bus_wr(2'd0, 8'h07, c0);
    q = {}; q.push_back(8'h07);
    check_line("frame_par", c0 + 2, q, 3, 1'b1);
    b0 = 8'($urandom);
    bus_wr(2'd0, b0, c0);
    q = {}; q.push_back(b0);
    check_line("frame_par_rand", c0 + 2, q, 3, 1'b1);
`else
    bus_wr(2'd1, 8'hFF, c);
    bus_rd(2'd1, d); chk("status_wr_ignored", d, 8'h02);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
